// File: rtl/pulse_meter_pkg.sv
// Shared types for the pulse period meter: measurement FSM state encoding.
package pulse_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Control and result bundle of the pulse period meter; master drives the pulse
// input and settings, slave is the meter reporting period/valid/timeout.
interface pulse_period_meter_if #(
    parameter int N = 8
);
    logic         ena;
    logic         in;
    logic [N-1:0] timeout_ticks;
    logic [N-1:0] period;
    logic         valid;
    logic         timeout;
    logic         saturated;

    modport master (
        output ena, in, timeout_ticks,
        input  period, valid, timeout, saturated
    );

    modport slave (
        input  ena, in, timeout_ticks,
        output period, valid, timeout, saturated
    );
endinterface

// File: rtl/pulse_period_meter_sync_rise_detect.sv
// Two-flop synchronizer plus history flop; rise is high for one cycle after a
// synchronized 0->1 transition of in. Reusable for any asynchronous input.
module sync_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic s1_r;
    logic s2_r;
    logic p_r;

    // Synchronizer chain and previous-value flop
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            p_r  <= 1'b0;
        end else begin
            s1_r <= in;
            s2_r <= s1_r;
            p_r  <= s2_r;
        end
    end

    assign rise = s2_r & ~p_r;
endmodule

// File: rtl/pulse_period_meter.sv
// Measures clocks between successive rising edges of bus.in, strobing valid
// with the period, and strobing timeout when edges stop arriving.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int N = 8
) (
    input logic                  clk,
    input logic                  rst,
    pulse_period_meter_if.slave  bus
);
    localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
    localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE  = N'(1'b1);

    meter_state_t state_r;
    meter_state_t state_s;
    logic [N-1:0] cnt_r;
    logic [N-1:0] cnt_s;
    logic [N-1:0] cnt_inc_s;
    logic [N-1:0] period_r;
    logic [N-1:0] period_s;
    logic         valid_r;
    logic         valid_s;
    logic         timeout_r;
    logic         timeout_s;
    logic         saturated_r;
    logic         saturated_s;
    logic         cnt_at_max_s;
    logic         tmo_hit_s;
    logic         rise_s;

    sync_rise_detect u_sync (
        .clk  (clk),
        .rst  (rst),
        .in   (bus.in),
        .rise (rise_s)
    );

    assign cnt_at_max_s = (cnt_r == CNT_MAX);
    assign cnt_inc_s    = cnt_at_max_s ? CNT_MAX : (cnt_r + CNT_ONE);
    // Threshold is read live so a mid-measurement change applies at once
    assign tmo_hit_s    = (bus.timeout_ticks != CNT_ZERO) &&
                          (cnt_r >= (bus.timeout_ticks - CNT_ONE));

    // Next-state and next-output decode; a rise always beats the timeout
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        period_s    = period_r;
        valid_s     = 1'b0;
        timeout_s   = 1'b0;
        saturated_s = saturated_r;
        if (!bus.ena) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_s = CNT_ZERO;
                    if (rise_s) begin
                        state_s = MEASURE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                MEASURE: begin
                    if (rise_s) begin
                        period_s    = cnt_inc_s;
                        valid_s     = 1'b1;
                        saturated_s = cnt_at_max_s;
                        cnt_s       = CNT_ZERO;
                    end else if (tmo_hit_s) begin
                        state_s   = IDLE;
                        timeout_s = 1'b1;
                        cnt_s     = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            period_r    <= CNT_ZERO;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
            saturated_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            period_r    <= period_s;
            valid_r     <= valid_s;
            timeout_r   <= timeout_s;
            saturated_r <= saturated_s;
        end
    end

    assign bus.period    = period_r;
    assign bus.valid     = valid_r;
    assign bus.timeout   = timeout_r;
    assign bus.saturated = saturated_r;
endmodule
